// File: rtl/axis_tile_deserializer.sv
// axis_tile_deserializer
//   Collects WORDS consecutive AXI-Stream beats into one parallel tile and
//   hands it to a valid/ready consumer. Frames shorter than WORDS beats are
//   emitted zero-padded and flagged short. Frames longer than WORDS beats are
//   emitted after WORDS beats and flagged long. The remaining beats of a long
//   frame are then dropped up to and including tlast.
//
// Ports
//   clk, rstn        : clock and asynchronous active-low reset
//   s_axis_*         : input stream (tdata, tvalid, tready, tlast, tuser)
//   m_tile_data      : assembled tile; beat k sits at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_tile_valid     : tile available (high exactly while holding a tile)
//   m_tile_ready     : consumer accepts the tile
//   m_tile_user      : tuser captured on the tile's first beat
//   m_tile_err       : 00 ok, 01 short frame, 10 long frame
//   err_count        : saturating count of tiles delivered with nonzero error
module axis_tile_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic [USER_WIDTH-1:0]       s_axis_tuser,
  output logic [WORDS*DATA_WIDTH-1:0] m_tile_data,
  output logic                        m_tile_valid,
  input  logic                        m_tile_ready,
  output logic [USER_WIDTH-1:0]       m_tile_user,
  output logic [1:0]                  m_tile_err,
  output logic [15:0]                 err_count
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    FULL    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   slot_q [WORDS];
  logic [DATA_WIDTH-1:0]   slot_d [WORDS];
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [1:0]              err_q, err_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    user_d    = user_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    for (int i = 0; i < WORDS; i++) slot_d[i] = slot_q[i];

    case (state_q)
      FILL: begin
        if (s_axis_tvalid) begin
          slot_d[cnt_q] = s_axis_tdata;
          if (cnt_q == '0) user_d = s_axis_tuser;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            // Tile is full: tlast here is a clean frame, otherwise the
            // frame overruns and its tail must be discarded afterwards.
            state_d = FULL;
            cnt_d   = '0;
            err_d   = s_axis_tlast ? 2'b00 : 2'b10;
            pend_d  = ~s_axis_tlast;
          end else if (s_axis_tlast) begin
            state_d = FULL;
            cnt_d   = '0;
            err_d   = 2'b01;
          end
        end
      end
      FULL: begin
        if (m_tile_ready) begin
          // Clearing slots here guarantees a following short frame reads
          // zero in the positions it never writes.
          for (int i = 0; i < WORDS; i++) slot_d[i] = '0;
          user_d = '0;
          err_d  = 2'b00;
          if (err_q != 2'b00 && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
          state_d = pend_q ? DISCARD : FILL;
        end
      end
      DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          pend_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      user_q    <= '0;
      err_q     <= 2'b00;
      err_cnt_q <= 16'd0;
      for (int i = 0; i < WORDS; i++) slot_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      user_q    <= user_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < WORDS; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Both handshake qualifiers decode the state register only, so the
  // consumer's ready never reaches s_axis_tready combinationally.
  assign s_axis_tready = (state_q != FULL);
  assign m_tile_valid  = (state_q == FULL);
  assign m_tile_user   = user_q;
  assign m_tile_err    = err_q;
  assign err_count     = err_cnt_q;

  for (genvar k = 0; k < WORDS; k++) begin : g_pack
    assign m_tile_data[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
  end

endmodule

// File: doc/axis_tile_deserializer.md
AXIS_TILE_DESERIALIZER -- requirements
Module: axis_tile_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the AXI-Stream beat width in bits.
REQ-002 SHALL have parameter WORDS, default 4 (>=2), giving the number of beats per tile.
REQ-003 SHALL have parameter USER_WIDTH, default 1, giving the tuser width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_axis_tdata  input  DATA_WIDTH  stream beat data.
REQ-007 SHALL have port s_axis_tvalid  input  1  beat valid.
REQ-008 SHALL have port s_axis_tready  output  1  beat accepted when high with tvalid.
REQ-009 SHALL have port s_axis_tlast  input  1  final beat of frame.
REQ-010 SHALL have port s_axis_tuser  input  USER_WIDTH  sideband, sampled on the first beat of a frame.
REQ-011 SHALL have port m_tile_data  output  WORDS*DATA_WIDTH  assembled tile; beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port m_tile_valid  output  1  tile available.
REQ-013 SHALL have port m_tile_ready  input  1  consumer accepts the tile when high with m_tile_valid.
REQ-014 SHALL have port m_tile_user  output  USER_WIDTH  tuser of the tile's first beat.
REQ-015 SHALL have port m_tile_err  output  2  00 ok, 01 short frame, 10 long frame.
REQ-016 SHALL have port err_count  output  16  saturating count of tiles emitted with nonzero m_tile_err.

Function
REQ-017 SHALL implement states FILL, FULL and DISCARD, plus a beat counter cnt of $clog2(WORDS) bits and a long-frame pending flag.
REQ-018 In FILL, s_axis_tready SHALL be 1; in FULL, 0; in DISCARD, 1.
REQ-019 In FILL, each handshake SHALL write s_axis_tdata into slot cnt and then increment cnt.
REQ-020 In FILL, a handshake with cnt==0 SHALL also capture s_axis_tuser.
REQ-021 A FILL handshake with cnt==WORDS-1 and tlast=1 SHALL enter FULL with err=00 and reset cnt to 0.
REQ-022 A FILL handshake with cnt<WORDS-1 and tlast=1 SHALL enter FULL with err=01; unwritten slots SHALL read 0.
REQ-023 A FILL handshake with cnt==WORDS-1 and tlast=0 SHALL enter FULL with err=10 and set the pending flag.
REQ-024 m_tile_valid SHALL be 1 exactly while in FULL, asserting the cycle after the final beat handshake (latency 1).
REQ-025 m_tile_data, m_tile_user and m_tile_err SHALL remain stable while m_tile_valid=1 and m_tile_ready=0.
REQ-026 A FULL handshake SHALL clear all data slots to 0 and go to DISCARD if the pending flag is set, else to FILL.
REQ-027 DISCARD SHALL drop accepted beats without storing them; a beat with tlast=1 SHALL clear the pending flag and return to FILL.
REQ-028 err_count SHALL increment by 1 on each FULL handshake with m_tile_err!=00 and SHALL saturate at 16'hFFFF.
REQ-029 s_axis_tready SHALL depend only on registered state; there SHALL be no combinational path from m_tile_ready to s_axis_tready.
REQ-030 Peak throughput SHALL be one tile per WORDS+1 cycles.
REQ-031 A single-beat frame (tlast on beat 0) SHALL yield err=01 with only slot 0 populated.

Reset
REQ-032 While rstn=0, the block SHALL be in state FILL with cnt=0, the pending flag 0 and all data slots 0.
REQ-033 While rstn=0, outputs SHALL be s_axis_tready=1, m_tile_valid=0, m_tile_data=0, m_tile_user=0, m_tile_err=00 and err_count=0.
REQ-034 Reset assertion in any state, including mid-frame or in DISCARD, SHALL abandon the partial tile immediately, asynchronously to clk.
REQ-035 After rstn deasserts, the first accepted beat SHALL be treated as beat 0 of a new frame.

Verification
REQ-036 Good frame, WORDS=4, DATA_WIDTH=8: beats 11,22,33,44 with tlast on 44 and m_tile_ready=1 SHALL give m_tile_data=32'h44332211, err=00 and m_tile_valid for 1 cycle, 1 cycle after beat 44.
REQ-037 Short frame: beats AA,BB with tlast on BB SHALL give m_tile_data=32'h0000BBAA, err=01 and err_count=1.
REQ-038 Long frame: beats 1..6 with tlast on 6 SHALL give a tile 32'h04030201 with err=10; beats 5,6 SHALL be dropped; a following good frame SHALL decode correctly.
REQ-039 Backpressure: holding m_tile_ready=0 for 10 cycles SHALL keep s_axis_tready=0 and the tile outputs stable; the tile SHALL be released on the first cycle m_tile_ready=1.
REQ-040 Reset mid-frame: asserting rstn=0 after 2 beats and then sending a fresh 4-beat frame SHALL give only the fresh tile, with err=00.
REQ-041 Saturation: preloading err_count to FFFF by forcing, then sending one short frame, SHALL leave err_count at FFFF.
